// File: rtl/neuron_layer_engine.sv
// neuron_layer_engine: sequencer and MAC datapath for one fully-connected layer.
// Each output neuron reads N activations from neuron_mem and N weights plus a
// bias from the weight ROM (row-major, N+1 words per neuron). It accumulates
// the products, adds the bias, applies ReLU with saturation, and writes the
// result back to neuron_mem.
//
// Ports:
//   clk, reset                  - posedge clock, synchronous active-high reset
//   start                       - one-cycle request, honoured only in IDLE
//   num_inputs, num_outputs     - N and M, latched on an accepted start
//   in_base, out_base, w_base   - base addresses, latched on an accepted start
//   input_addr / neuron_val     - activation read port (one-cycle latency)
//   weight_addr / weight_val    - weight ROM read port (one-cycle latency)
//   write_enable, output_addr,
//   data                        - one-cycle result write strobe
//   busy, done                  - status; done pulses once per job
module neuron_layer_engine #(
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic        [11:0] num_inputs,
    input  logic        [11:0] num_outputs,
    input  logic        [11:0] in_base,
    input  logic        [11:0] out_base,
    input  logic        [15:0] w_base,
    output logic        [11:0] input_addr,
    input  logic signed [15:0] neuron_val,
    output logic        [15:0] weight_addr,
    input  logic signed [15:0] weight_val,
    output logic               write_enable,
    output logic        [11:0] output_addr,
    output logic signed [15:0] data,
    output logic               busy,
    output logic               done
);

    localparam int unsigned AW      = 12;
    localparam int unsigned DW      = 16;
    localparam int unsigned PW      = 2 * DW;
    localparam int          SAT_MAX = 32767;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_BIAS,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state;
    logic        [AW-1:0]     n_q;
    logic        [AW-1:0]     m_q;
    logic        [AW-1:0]     in_base_q;
    logic        [AW-1:0]     out_base_q;
    logic        [AW-1:0]     i_q;
    logic        [AW-1:0]     j_q;
    logic signed [DW-1:0]     act_q;
    logic signed [DW-1:0]     w_q;
    logic signed [ACC_W-1:0]  acc;

    logic signed [PW-1:0]     prod_c;
    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [ACC_W-1:0]  acc_bias_c;
    logic signed [ACC_W-1:0]  shifted_c;
    logic signed [DW-1:0]     result_c;

    // Product of the previously sampled operand pair, bias add, ReLU and saturation.
    always_comb begin
        prod_c     = PW'(act_q) * PW'(w_q);
        prod_ext_c = ACC_W'(prod_c);
        acc_bias_c = acc + (ACC_W'(w_q) <<< FRAC_BITS);
        shifted_c  = acc_bias_c >>> FRAC_BITS;
        if (shifted_c[ACC_W-1]) begin
            result_c = '0;
        end else if (shifted_c > ACC_W'(SAT_MAX)) begin
            result_c = DW'(SAT_MAX);
        end else begin
            result_c = DW'(shifted_c);
        end
    end

    // Sequencer; all outputs are registered. Operands sampled at the end of
    // one cycle are multiplied and accumulated at the end of the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            n_q          <= '0;
            m_q          <= '0;
            in_base_q    <= '0;
            out_base_q   <= '0;
            i_q          <= '0;
            j_q          <= '0;
            act_q        <= '0;
            w_q          <= '0;
            acc          <= '0;
            input_addr   <= '0;
            weight_addr  <= '0;
            write_enable <= 1'b0;
            output_addr  <= '0;
            data         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q        <= num_inputs;
                        m_q        <= num_outputs;
                        in_base_q  <= in_base;
                        out_base_q <= out_base;
                        i_q        <= '0;
                        j_q        <= '0;
                        acc        <= '0;
                        busy       <= 1'b1;
                        if (num_outputs == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            input_addr  <= in_base;
                            weight_addr <= w_base;
                            state       <= (num_inputs != '0) ? S_MAC : S_DRAIN;
                        end
                    end
                end
                S_MAC: begin
                    act_q       <= neuron_val;
                    w_q         <= weight_val;
                    if (i_q != '0) begin
                        acc <= acc + prod_ext_c;
                    end
                    input_addr  <= input_addr + AW'(1);
                    weight_addr <= weight_addr + 16'd1;
                    if (i_q == n_q - AW'(1)) begin
                        i_q   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        i_q <= i_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    // weight_val now carries the bias word for this neuron
                    w_q <= weight_val;
                    if (n_q != '0) begin
                        acc <= acc + prod_ext_c;
                    end
                    weight_addr <= weight_addr + 16'd1;
                    state       <= S_BIAS;
                end
                S_BIAS: begin
                    data         <= result_c;
                    output_addr  <= out_base_q + j_q;
                    write_enable <= 1'b1;
                    state        <= S_WRITE;
                end
                S_WRITE: begin
                    acc <= '0;
                    if (j_q == m_q - AW'(1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        j_q        <= j_q + AW'(1);
                        input_addr <= in_base_q;
                        state      <= (n_q != '0) ? S_MAC : S_DRAIN;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_engine.sv
// Directed bench for neuron_layer_engine: one instance with FRAC_BITS=0 and
// one with FRAC_BITS=8, sharing a negedge-updated neuron memory and weight ROM.
module tb_neuron_layer_engine;

    logic clk;
    logic reset;
    logic start0, start8;
    logic [11:0] num_inputs, num_outputs, in_base, out_base;
    logic [15:0] w_base;

    logic [11:0] iaddr0, oaddr0, iaddr8, oaddr8;
    logic [15:0] waddr0, waddr8;
    logic signed [15:0] nval0, wval0, data0, nval8, wval8, data8;
    logic we0, busy0, done0, we8, busy8, done8;

    logic signed [15:0] mem [0:4095];
    logic signed [15:0] rom [0:65535];

    logic        tb_we, tb_rom;
    logic [15:0] tb_addr;
    logic [15:0] tb_data;

    int n_checks = 0;
    int n_errors = 0;

    int wr_n, done_n, done_cyc, busy_err;
    int wr_cyc [0:7];
    int wr_adr [0:7];
    int wr_dat [0:7];
    bit saw_w9, rst_zero;

    neuron_layer_engine #(.FRAC_BITS(0), .ACC_W(40)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .num_inputs(num_inputs), .num_outputs(num_outputs),
        .in_base(in_base), .out_base(out_base), .w_base(w_base),
        .input_addr(iaddr0), .neuron_val(nval0),
        .weight_addr(waddr0), .weight_val(wval0),
        .write_enable(we0), .output_addr(oaddr0), .data(data0),
        .busy(busy0), .done(done0)
    );

    neuron_layer_engine #(.FRAC_BITS(8), .ACC_W(40)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .num_inputs(num_inputs), .num_outputs(num_outputs),
        .in_base(in_base), .out_base(out_base), .w_base(w_base),
        .input_addr(iaddr8), .neuron_val(nval8),
        .weight_addr(waddr8), .weight_val(wval8),
        .write_enable(we8), .output_addr(oaddr8), .data(data8),
        .busy(busy8), .done(done8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory and ROM: writes commit and read data updates on the negedge.
    always @(negedge clk) begin
        if (tb_we) begin
            if (tb_rom) rom[tb_addr] = tb_data;
            else        mem[tb_addr[11:0]] = tb_data;
        end
        if (we0) mem[oaddr0] = data0;
        if (we8) mem[oaddr8] = data8;
        nval0 <= mem[iaddr0];
        wval0 <= rom[waddr0];
        nval8 <= mem[iaddr8];
        wval8 <= rom[waddr8];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic poke(input bit is_rom, input int addr, input int val);
        @(posedge clk);
        #1;
        tb_rom  = is_rom;
        tb_addr = 16'(addr);
        tb_data = 16'(val);
        tb_we   = 1'b1;
        @(negedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    // Start one job on the selected instance and watch cycles 1..ncyc.
    // glitch_k: cycle in which a stray start (with altered config) is driven.
    // rst_k: cycle in which reset is driven (sampled at the end of that cycle).
    task automatic run_job(input bit sel, input int n, input int m, input int ib,
                           input int ob, input int wb, input int busy_last,
                           input int ncyc, input int glitch_k, input int rst_k);
        bit b, d, we;
        wr_n = 0; done_n = 0; done_cyc = -1; busy_err = 0;
        saw_w9 = 1'b0; rst_zero = 1'b0;
        @(negedge clk);
        num_inputs  = 12'(n);
        num_outputs = 12'(m);
        in_base     = 12'(ib);
        out_base    = 12'(ob);
        w_base      = 16'(wb);
        if (sel) start8 = 1'b1;
        else     start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start8 = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            b  = sel ? busy8 : busy0;
            d  = sel ? done8 : done0;
            we = sel ? we8 : we0;
            if (we) begin
                if (wr_n < 8) begin
                    wr_cyc[wr_n] = k;
                    wr_adr[wr_n] = sel ? int'(oaddr8) : int'(oaddr0);
                    wr_dat[wr_n] = sel ? int'(data8) : int'(data0);
                end
                wr_n++;
            end
            if (d) begin
                done_n++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (b != (k <= busy_last)) busy_err++;
            if ((sel ? waddr8 : waddr0) == 16'd9) saw_w9 = 1'b1;
            if (k == rst_k + 1) begin
                rst_zero = sel ? (!busy8 && !done8 && !we8 && iaddr8 == 0 && oaddr8 == 0 &&
                                  data8 == 0 && waddr8 == 0)
                               : (!busy0 && !done0 && !we0 && iaddr0 == 0 && oaddr0 == 0 &&
                                  data0 == 0 && waddr0 == 0);
            end
            reset = (k == rst_k);
            if (k == glitch_k) begin
                num_outputs = 12'd1;
                out_base    = 12'd200;
                if (sel) start8 = 1'b1;
                else     start0 = 1'b1;
            end else begin
                start0 = 1'b0;
                start8 = 1'b0;
            end
        end
        reset  = 1'b0;
        start0 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic load_basic_rom();
        poke(1, 0, 1); poke(1, 1, 2); poke(1, 2, -1); poke(1, 3, 3); poke(1, 4, 10);
    endtask

    task automatic check_basic(input string pfx);
        check({pfx, "_wr_n"}, wr_n, 1);
        check({pfx, "_wr_cyc"}, wr_cyc[0], 7);
        check({pfx, "_wr_adr"}, wr_adr[0], 16);
        check({pfx, "_wr_dat"}, wr_dat[0], 30);
        check({pfx, "_mem16"}, int'(mem[16]), 30);
        check({pfx, "_done_cyc"}, done_cyc, 8);
        check({pfx, "_done_n"}, done_n, 1);
        check({pfx, "_busy"}, busy_err, 0);
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start8 = 1'b0;
        tb_we = 1'b0; tb_rom = 1'b0; tb_addr = '0; tb_data = '0;
        num_inputs = '0; num_outputs = '0; in_base = '0; out_base = '0; w_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy0) + int'(busy8), 0);
        check("rst_done", int'(done0) + int'(done8), 0);
        check("rst_we", int'(we0) + int'(we8), 0);
        check("rst_iaddr", int'(iaddr0 | iaddr8), 0);
        check("rst_oaddr", int'(oaddr0 | oaddr8), 0);
        check("rst_data", int'(data0 | data8), 0);
        check("rst_waddr", int'(waddr0 | waddr8), 0);
        reset = 1'b0;

        poke(0, 0, 7); poke(0, 1, 5); poke(0, 2, 9); poke(0, 3, 4);
        poke(0, 16, 0); poke(0, 17, 0);

        // basic MAC: 7*1 + 5*2 - 9 + 4*3 + 10 = 30
        load_basic_rom();
        run_job(0, 4, 1, 0, 16, 0, 8, 12, 0, 0);
        check_basic("basic");

        // ReLU: -25 clamps to 0
        poke(1, 0, -1); poke(1, 1, -1); poke(1, 2, -1); poke(1, 3, -1); poke(1, 4, 0);
        run_job(0, 4, 1, 0, 16, 0, 8, 12, 0, 0);
        check("relu_dat", wr_dat[0], 0);
        check("relu_mem16", int'(mem[16]), 0);

        // two neurons: 25 then 5, with a stray start in cycle 5
        poke(1, 0, 1); poke(1, 1, 1); poke(1, 2, 1); poke(1, 3, 1); poke(1, 4, 0);
        poke(1, 5, 0); poke(1, 6, 0); poke(1, 7, 0); poke(1, 8, 1); poke(1, 9, 1);
        run_job(0, 4, 2, 0, 16, 0, 15, 19, 5, 0);
        check("multi_wr_n", wr_n, 2);
        check("multi_cyc0", wr_cyc[0], 7);
        check("multi_adr0", wr_adr[0], 16);
        check("multi_dat0", wr_dat[0], 25);
        check("multi_cyc1", wr_cyc[1], 14);
        check("multi_adr1", wr_adr[1], 17);
        check("multi_dat1", wr_dat[1], 5);
        check("multi_mem17", int'(mem[17]), 5);
        check("multi_done", done_cyc, 15);
        check("multi_w9", int'(saw_w9), 1);
        check("multi_busy", busy_err, 0);

        // N=0: result is the bias alone
        poke(1, 20, 42);
        run_job(0, 0, 1, 0, 16, 20, 4, 7, 0, 0);
        check("n0_wr_n", wr_n, 1);
        check("n0_cyc", wr_cyc[0], 3);
        check("n0_mem16", int'(mem[16]), 42);
        check("n0_done", done_cyc, 4);
        check("n0_busy", busy_err, 0);

        // M=0: done in cycle 1, no write
        run_job(0, 4, 0, 0, 16, 0, 1, 5, 0, 0);
        check("m0_done", done_cyc, 1);
        check("m0_wr_n", wr_n, 0);
        check("m0_busy", busy_err, 0);

        // reset during MAC cycle 2, then a clean rerun
        poke(0, 16, 99);
        load_basic_rom();
        run_job(0, 4, 1, 0, 16, 0, 2, 12, 0, 2);
        check("rst_outs_zero", int'(rst_zero), 1);
        check("rst_wr_n", wr_n, 0);
        check("rst_done", done_n, 0);
        check("rst_mem16", int'(mem[16]), 99);
        check("rst_busy", busy_err, 0);
        run_job(0, 4, 1, 0, 16, 0, 8, 12, 0, 0);
        check_basic("rerun");

        // FRAC_BITS=8: 30000 * 2.0 saturates
        poke(0, 32, 16'h7530); poke(1, 100, 16'h0200); poke(1, 101, 0);
        run_job(1, 1, 1, 32, 40, 100, 5, 8, 0, 0);
        check("sat_dat", wr_dat[0], 32767);
        check("sat_mem40", int'(mem[40]), 32767);
        check("sat_cyc", wr_cyc[0], 4);

        // FRAC_BITS=8: 1.5 * 3.0 + 0.25 = 4.75 = 0x04C0
        poke(0, 33, 16'h0180); poke(1, 102, 16'h0300); poke(1, 103, 16'h0040);
        run_job(1, 1, 1, 33, 41, 102, 5, 8, 0, 0);
        check("frac_dat", wr_dat[0], 16'h04C0);
        check("frac_done", done_cyc, 5);

        // address wrap: activations at 4095,0; weights at 65535,0, bias at 1
        poke(0, 4095, 3); poke(1, 65535, 2); poke(1, 0, 3); poke(1, 1, 5);
        run_job(0, 2, 1, 4095, 100, 65535, 6, 9, 0, 0);
        check("wrap_dat", wr_dat[0], 32);
        check("wrap_adr", wr_adr[0], 100);
        check("wrap_done", done_cyc, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
